mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Two-requester round-robin arbiter that shares a single width-parameterised 2:1 select datapath (the ITE/mux path) between two valid/ready producers. It picks one requester per cycle, steers that requester's data through the mux, and registers the result into a one-entry output stage with valid/ready backpressure. It sits in front of any consumer that needs a single arbitrated stream from two sources.

## Interface
- width, default 1: data width of each requester and of the output.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- I0_valid  in  1  requester 0 has data.
- I0_data  in  width  requester 0 payload.
- I0_ready  out  1  requester 0 transfer accepted this cycle.
- I1_valid  in  1  requester 1 has data.
- I1_data  in  width  requester 1 payload.
- I1_ready  out  1  requester 1 transfer accepted this cycle.
- O_valid  out  1  output register holds data.
- O_data  out  width  registered arbitrated payload.
- O_ready  in  1  consumer accepts O_data this cycle.
- S  out  1  source tag of O_data (0 = I0, 1 = I1).

## Operation
- Transfer on any port occurs when valid and ready are both high at a rising CLK edge.
- accept = !O_valid | O_ready (output stage empty or draining this cycle).
- Priority pointer `last` (1 bit) records the requester most recently granted.
- Winner selection (combinational, only when accept):
  - only I0_valid: grant 0; only I1_valid: grant 1.
  - both valid: grant !last (the requester not served last).
  - neither: no grant.
- I0_ready = accept & grant==0 & I0_valid; I1_ready = accept & grant==1 & I1_valid. Exactly one ready high at most per cycle.
- Mux select = grant; mux output feeds O_data register.
- On edge with a grant: O_data <= selected data, S <= grant, O_valid <= 1, last <= grant.
- On edge with accept and no grant: O_valid <= 0; O_data, S, last hold.
- On edge without accept (O_valid & !O_ready): all state holds; O_data/S stable until consumed.
- Readies depend on O_valid, O_ready and both valids; valids must not depend on readies.
- Pointer advances only on an actual grant; an idle requester never loses its turn.

## Timing
- Reset (RESET high at edge): O_valid=0, O_data=0, S=0, last=1 (so I0 wins the first tie). I0_ready/I1_ready are 0 while O_valid=0 holds only if no valid is present; readies are combinational from post-reset state.
- Latency: input transfer at edge N -> O_valid/O_data at output after edge N, consumable at edge N+1.
- Throughput: one transfer per cycle with O_ready held high; with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Stall: O_ready low with O_valid high -> both readies 0, no pointer movement.
- Simultaneous consume and load: O_valid & O_ready & winner present -> register reloads same edge, O_valid stays 1, no bubble.
- RESET mid-operation overrides all: in-flight O_data is dropped, pointer returns to last=1; no requester transfer is acknowledged in the reset cycle (readies forced 0 while RESET high).

## Structure
- Shared package: width default (1), grant constants GRANT_I0=0 / GRANT_I1=1, reset pointer value LAST_RESET=1.
- Sub-module mux_rr_pick: combinational winner logic (inputs I0_valid, I1_valid, last, accept; outputs grant_valid, grant). Datapath select uses the existing width-parameterised 2:1 mux primitive; output register, pointer and readies live in the top.

## Test plan
- Reset: hold RESET 2 cycles with both valids high -> readies 0, O_valid=0, O_data=0, S=0.
- Tie-break/alternation (width=8): I0=0x11, I1=0x22 both valid, O_ready=1 for 4 cycles -> O_data sequence 0x11,0x22,0x11,0x22; S 0,1,0,1.
- Single requester: only I1_valid with 0xA5 for 3 cycles -> I1_ready every cycle, O_data 0xA5 each, S=1; then I0 and I1 both valid -> I0 granted (last=1).
- Backpressure: O_valid=1 holding 0x11, O_ready=0 for 3 cycles with both valid -> readies 0, O_data/S unchanged, pointer unchanged; O_ready=1 -> I1 granted next.
- Drain: no valids, O_ready=1 -> O_valid falls to 0 after one edge, O_data holds last value.
- Reset mid-stream: assert RESET while O_valid=1 -> next cycle O_valid=0, S=0; first tie after release grants I0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the two-requester round-robin arbiter.
// Grant encodings double as the mux select and as the S source tag.
package mux_rr_arbiter_pkg;

   localparam int WIDTH_DEFAULT = 1;

   localparam logic GRANT_I0   = 1'b0;
   localparam logic GRANT_I1   = 1'b1;
   localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin winner selection between two requesters.
// A tie goes to the requester that was not granted most recently.
module mux_rr_pick
   import mux_rr_arbiter_pkg::*;
(
   input  logic I0_valid,
   input  logic I1_valid,
   input  logic last,
   input  logic accept,
   output logic grant_valid,
   output logic grant
);

   always_comb begin
      grant_valid = 1'b0;
      grant       = GRANT_I0;
      if (accept) begin
         if (I0_valid && I1_valid) begin
            grant_valid = 1'b1;
            grant       = ~last;
         end else if (I1_valid) begin
            grant_valid = 1'b1;
            grant       = GRANT_I1;
         end else if (I0_valid) begin
            grant_valid = 1'b1;
            grant       = GRANT_I0;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage.
// The winner's payload is steered through a shared 2:1 select path into O_data.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int width = WIDTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I0_valid,
   input  logic [width-1:0] I0_data,
   output logic             I0_ready,
   input  logic             I1_valid,
   input  logic [width-1:0] I1_data,
   output logic             I1_ready,
   output logic             O_valid,
   output logic [width-1:0] O_data,
   input  logic             O_ready,
   output logic             S
);

   logic             o_valid_q, o_valid_d;
   logic [width-1:0] o_data_q, o_data_d;
   logic             s_q, s_d;
   logic             last_q, last_d;

   logic             accept;
   logic             grant_valid;
   logic             grant;
   logic [width-1:0] mux_out;

   assign accept = ~o_valid_q | O_ready;

   mux_rr_pick u_pick (
      .I0_valid    (I0_valid),
      .I1_valid    (I1_valid),
      .last        (last_q),
      .accept      (accept),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign mux_out = (grant == GRANT_I1) ? I1_data : I0_data;

   // Readies are suppressed during reset so no transfer is acknowledged then.
   assign I0_ready = ~RESET & grant_valid & (grant == GRANT_I0) & I0_valid;
   assign I1_ready = ~RESET & grant_valid & (grant == GRANT_I1) & I1_valid;

   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      s_d       = s_q;
      last_d    = last_q;
      if (grant_valid) begin
         o_valid_d = 1'b1;
         o_data_d  = mux_out;
         s_d       = grant;
         last_d    = grant;
      end else if (accept) begin
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         s_q       <= GRANT_I0;
         last_q    <= LAST_RESET;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         s_q       <= s_d;
         last_q    <= last_d;
      end
   end

   assign O_valid = o_valid_q;
   assign O_data  = o_data_q;
   assign S       = s_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed plus randomized bench for mux_rr_arbiter against a turn-based model.
module tb_mux_rr_arbiter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         i0_valid, i1_valid, o_ready;
   logic [W-1:0] i0_data, i1_data;
   logic         i0_ready, i1_ready, o_valid, s;
   logic [W-1:0] o_data;

   int checks   = 0;
   int failures = 0;

   // Model state: what the output stage should hold and whose turn a tie is.
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_src;
   int           m_turn;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.width(W)) dut (
      .CLK      (clk),
      .RESET    (rst),
      .I0_valid (i0_valid),
      .I0_data  (i0_data),
      .I0_ready (i0_ready),
      .I1_valid (i1_valid),
      .I1_data  (i1_data),
      .I1_ready (i1_ready),
      .O_valid  (o_valid),
      .O_data   (o_data),
      .O_ready  (o_ready),
      .S        (s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle: check readies before the edge, outputs after it.
   task automatic step(input logic v0, input logic [W-1:0] d0, input logic v1,
                       input logic [W-1:0] d1, input logic ordy, input logic r);
      int winner;
      bit can_take;
      i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1;
      o_ready = ordy; rst = r;
      #2;
      can_take = !m_valid || ordy;
      if (v0 && v1)  winner = m_turn;
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
      else           winner = -1;
      if (!can_take) winner = -1;
      chk("i0_ready", {31'd0, i0_ready}, {31'd0, (!r && winner == 0)});
      chk("i1_ready", {31'd0, i1_ready}, {31'd0, (!r && winner == 1)});
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_turn = 0;
      end else if (winner >= 0) begin
         m_valid = 1'b1;
         m_data  = (winner == 1) ? d1 : d0;
         m_src   = winner[0];
         m_turn  = 1 - winner;
      end else if (can_take) begin
         m_valid = 1'b0;
      end
      #1;
      chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
      chk("s", {31'd0, s}, {31'd0, m_src});
      if (m_valid || r) chk("o_data", {24'd0, o_data}, {24'd0, m_data});
   endtask

   initial begin
      m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_turn = 0;
      rst = 1'b1; i0_valid = 1'b0; i1_valid = 1'b0; o_ready = 1'b0;
      i0_data = '0; i1_data = '0;
      @(posedge clk); #1;

      // Reset with both valids high.
      step(1, 8'h11, 1, 8'h22, 1, 1);
      step(1, 8'h11, 1, 8'h22, 1, 1);
      chk("reset_o_data", {24'd0, o_data}, 32'h0);

      // Alternation on a sustained tie: 0x11, 0x22, 0x11, 0x22.
      step(1, 8'h11, 1, 8'h22, 1, 0);
      chk("alt0", {23'd0, s, o_data}, {23'd0, 1'b0, 8'h11});
      step(1, 8'h11, 1, 8'h22, 1, 0);
      chk("alt1", {23'd0, s, o_data}, {23'd0, 1'b1, 8'h22});
      step(1, 8'h11, 1, 8'h22, 1, 0);
      chk("alt2", {23'd0, s, o_data}, {23'd0, 1'b0, 8'h11});
      step(1, 8'h11, 1, 8'h22, 1, 0);
      chk("alt3", {23'd0, s, o_data}, {23'd0, 1'b1, 8'h22});

      // Single requester keeps winning; then a tie goes to I0.
      repeat (3) begin
         step(0, 8'h00, 1, 8'hA5, 1, 0);
         chk("single_i1", {23'd0, s, o_data}, {23'd0, 1'b1, 8'hA5});
      end
      step(1, 8'h11, 1, 8'h22, 1, 0);
      chk("tie_after_i1", {31'd0, s}, 32'd0);

      // Backpressure: output holds 0x11, pointer frozen, then I1 wins.
      repeat (3) begin
         step(1, 8'h33, 1, 8'h44, 0, 0);
         chk("stall_hold", {23'd0, s, o_data}, {23'd0, 1'b0, 8'h11});
      end
      step(1, 8'h33, 1, 8'h44, 1, 0);
      chk("after_stall", {23'd0, s, o_data}, {23'd0, 1'b1, 8'h44});

      // Drain: valid drops, data holds.
      step(0, 8'h00, 0, 8'h00, 1, 0);
      chk("drain_valid", {31'd0, o_valid}, 32'd0);
      chk("drain_data", {24'd0, o_data}, 32'h44);

      // Reset mid-stream, then the first tie goes to I0.
      step(1, 8'h55, 0, 8'h00, 0, 0);
      step(1, 8'h66, 1, 8'h77, 0, 1);
      chk("midrst_valid", {31'd0, o_valid}, 32'd0);
      step(1, 8'h66, 1, 8'h77, 1, 0);
      chk("midrst_tie", {23'd0, s, o_data}, {23'd0, 1'b0, 8'h66});

      // Randomized traffic with occasional reset.
      repeat (300) begin
         step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
